uart_bus_master: RTL and testbench
==================================

// Module: uart_bus_master
// PURPOSE
// Bus initiator driven by a byte stream from the UART receiver: parses host command frames and
// issues single-cycle rd/wr transfers on the peripheral bus (the same rd/wr/addr/wdata/rdata
// interface the peripheral block responds on). It returns read data or a write acknowledge as
// bytes to the UART sender. Used for host-side debug, register poking and program loading.
// PARAMETERS
// TIMEOUT_CYC  100000  idle cycles allowed between frame bytes before the parser aborts (>=2)
// ACK_BYTE     8'h4B   response byte after a completed write ('K')
// ERR_BYTE     8'h3F   response byte for an unknown command ('?')
// PORTS
// clk        in   1   system clock
// reset      in   1   synchronous, active-high reset
// rx_data    in   8   byte from the UART receiver
// rx_valid   in   1   one-cycle strobe: rx_data is valid
// tx_data    out  8   byte to the UART sender
// tx_valid   out  1   tx_data valid; held until accepted
// tx_ready   in   1   sender can take a byte; transfer occurs when tx_valid&&tx_ready
// rd         out  1   bus read strobe (one cycle)
// wr         out  1   bus write strobe (one cycle)
// addr       out  32  bus address
// wdata      out  32  bus write data
// rdata      in   32  bus read data; combinational, valid in the same cycle as rd
// busy       out  1   high whenever state != IDLE
// BEHAVIOUR
// - One clock, clk. reset is synchronous and active-high: on posedge clk with reset=1, state=IDLE
//   and all outputs are 0 (rd, wr, tx_valid, busy, tx_data, addr, wdata); byte counter and
//   timeout counter are cleared. A frame in progress is discarded; no response is sent.
// - Frame format (bytes, MSB first): 'W'(8'h57) A3 A2 A1 A0 D3 D2 D1 D0 | 'R'(8'h52) A3 A2 A1 A0.
// - States: IDLE, ADDR, DATA, ISSUE, RESP.
//   IDLE:  on rx_valid: 'W'/'R' -> latch the command, clear cnt -> ADDR. Any other byte ->
//          tx_data=ERR_BYTE, 1-byte response -> RESP.
//   ADDR:  each rx_valid shifts the byte into addr (addr<={addr[23:0],rx_data}), cnt++; after the
//          4th byte -> DATA if 'W', else ISSUE.
//   DATA:  same scheme into wdata; after the 4th byte -> ISSUE.
//   ISSUE: exactly one cycle. 'W': wr=1. 'R': rd=1, and rdata is captured into a 32-bit response
//          shift register in the same cycle. -> RESP. addr/wdata stay stable during the strobe.
//   RESP:  'W' sends 1 byte (ACK_BYTE). 'R' sends 4 bytes, rdata[31:24] first. tx_valid is held
//          with tx_data stable until tx_ready; the next byte is presented the cycle after a
//          handshake. After the final handshake -> IDLE.
// - Latency: wr/rd is asserted 1 cycle after the clock that accepts the last frame byte.
//   tx_valid rises in the cycle after ISSUE.
// - rx_valid in ISSUE or RESP is dropped (the host must wait for the response). No buffering.
// - Timeout: in ADDR/DATA a counter increments every cycle without rx_valid and clears on
//   rx_valid. When it reaches TIMEOUT_CYC-1 -> IDLE silently; no bus strobe; addr/wdata keep
//   their partial values.
// - rd and wr are never high in the same cycle and are never high outside ISSUE.
// - addr/wdata hold their last values in IDLE. Transfers are unaligned-agnostic: no checks.
// TESTING
// - Write frame 57 40 00 00 0C 00 00 00 A5 -> one wr pulse with addr=32'h4000000C,
//   wdata=32'h000000A5; then tx byte 4B.
// - Read frame 52 40 00 00 10 with rdata=32'h0000005A in ISSUE -> one rd pulse,
//   addr=32'h40000010; tx bytes 00 00 00 5A in order.
// - Hold tx_ready=0 for 20 cycles during a read response -> tx_valid stays 1 and tx_data stays
//   00; no byte is skipped or repeated when ready returns.
// - Byte 8'h41 in IDLE -> tx 3F, no rd/wr. Next valid frame then executes normally.
// - Send 57 40 00 then stall TIMEOUT_CYC cycles -> back to IDLE (busy=0), no wr. A fresh
//   read frame then completes correctly.
// - Assert reset for 1 cycle mid-DATA and mid-RESP -> all outputs 0 next cycle, no strobe,
//   no further tx; next frame works.

Source files
------------

// File: rtl/uart_bus_master.sv
// Host command parser: turns 'W'/'R' byte frames from the UART receiver into single-cycle
// bus transfers and streams the write acknowledge or read data back to the UART sender.
module uart_bus_master #(
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [7:0]  ACK_BYTE    = 8'h4B,
  parameter logic [7:0]  ERR_BYTE    = 8'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy
);

  localparam int             TW      = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     CMD_W   = 8'h57;
  localparam logic [7:0]     CMD_R   = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_ISSUE, S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   resp_q, resp_d;
  logic [2:0]    left_q, left_d;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      is_wr_q  <= 1'b0;
      cnt_q    <= '0;
      to_cnt_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      left_q   <= '0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      cnt_q    <= cnt_d;
      to_cnt_q <= to_cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      resp_q   <= resp_d;
      left_q   <= left_d;
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    cnt_d    = cnt_q;
    to_cnt_d = to_cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    resp_d   = resp_q;
    left_d   = left_q;

    unique case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (rx_valid) begin
          if (rx_data == CMD_W || rx_data == CMD_R) begin
            is_wr_d = (rx_data == CMD_W);
            cnt_d   = '0;
            state_d = S_ADDR;
          end else begin
            resp_d  = {ERR_BYTE, 24'h0};
            left_d  = 3'd1;
            state_d = S_RESP;
          end
        end
      end

      S_ADDR, S_DATA: begin
        if (rx_valid) begin
          if (state_q == S_ADDR) addr_d  = {addr_q[23:0], rx_data};
          else                   wdata_d = {wdata_q[23:0], rx_data};
          to_cnt_d = '0;
          cnt_d    = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = (state_q == S_ADDR && is_wr_q) ? S_DATA : S_ISSUE;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // Host went quiet mid-frame: drop it without a strobe or response.
          to_cnt_d = '0;
          state_d  = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_ISSUE: begin
        if (is_wr_q) begin
          resp_d = {ACK_BYTE, 24'h0};
          left_d = 3'd1;
        end else begin
          resp_d = rdata;
          left_d = 3'd4;
        end
        state_d = S_RESP;
      end

      S_RESP: begin
        if (tx_ready) begin
          resp_d = {resp_q[23:0], 8'h00};
          left_d = left_q - 3'd1;
          if (left_q == 3'd1) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd       = (state_q == S_ISSUE) && !is_wr_q;
    wr       = (state_q == S_ISSUE) &&  is_wr_q;
    tx_valid = (state_q == S_RESP);
    tx_data  = resp_q[31:24];
    busy     = (state_q != S_IDLE);
    addr     = addr_q;
    wdata    = wdata_q;
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: directed frames from the host-side scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_uart_bus_master;

  localparam int         TO  = 40;
  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] ERR = 8'h3F;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        rd, wr, busy;
  logic [31:0] addr, wdata, rdata, rdata_val;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_addr;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];
  logic [7:0]  tx_q[$];
  int          overlap = 0;

  uart_bus_master #(.TIMEOUT_CYC(TO), .ACK_BYTE(ACK), .ERR_BYTE(ERR)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // The peripheral only returns meaningful data while rd is high.
  assign rdata = rd ? rdata_val : 32'hDEADBEEF;

  always @(negedge clk) begin
    if (wr) begin
      wr_addr_q.push_back(addr);
      wr_data_q.push_back(wdata);
    end
    if (rd) rd_addr_q.push_back(addr);
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (rd && wr) overlap++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic drive_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                             input int max_gap);
    logic [7:0] q[$];
    q.push_back(cmd);
    if (cmd == 8'h57 || cmd == 8'h52)
      for (int i = 0; i < 4; i++) q.push_back(a[31-8*i -: 8]);
    if (cmd == 8'h57)
      for (int i = 0; i < 4; i++) q.push_back(d[31-8*i -: 8]);
    for (int i = 0; i < q.size(); i++)
      send_byte(q[i], (i == q.size() - 1) ? 0 : $urandom_range(0, max_gap));
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready);
    int n = 0;
    while (busy && n < budget) begin
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    tx_ready = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1; rdata_val = '0;
    repeat (2) tick();
    checks++;
    if ({rd, wr, tx_valid, busy, tx_data, addr, wdata} !== '0) begin
      failures++;
      $display("FAIL reset_state: rd=%b wr=%b tx_valid=%b busy=%b tx_data=%h addr=%h wdata=%h, required all 0",
               rd, wr, tx_valid, busy, tx_data, addr, wdata);
    end
    reset = 1'b0;
    model_addr = '0;
    tick();
  endtask

  task automatic test_write();
    int wb = wr_addr_q.size(), rb = rd_addr_q.size(), tb0 = tx_q.size();
    drive_frame(8'h57, 32'h4000000C, 32'h000000A5, 0);
    checks++;
    if (wr !== 1'b1 || rd !== 1'b0 || addr !== 32'h4000000C || wdata !== 32'h000000A5) begin
      failures++;
      $display("FAIL write_strobe: wr=%b rd=%b addr=%h wdata=%h, required wr=1 rd=0 addr=4000000c wdata=000000a5",
               wr, rd, addr, wdata);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== ACK || wr !== 1'b0) begin
      failures++;
      $display("FAIL write_ack_latency: tx_valid=%b tx_data=%h wr=%b, required 1 %h 0", tx_valid, tx_data, wr, ACK);
    end
    wait_idle(50, 1'b0);
    checks++;
    if (wr_addr_q.size() - wb != 1 || rd_addr_q.size() != rb || tx_q.size() - tb0 != 1) begin
      failures++;
      $display("FAIL write_counts: wr=%0d rd=%0d tx=%0d, required 1 0 1",
               wr_addr_q.size() - wb, rd_addr_q.size() - rb, tx_q.size() - tb0);
    end else begin
      checks++;
      if (tx_q[tb0] !== ACK) begin
        failures++;
        $display("FAIL write_ack_byte: got %h, required %h", tx_q[tb0], ACK);
      end
    end
    model_addr = 32'h4000000C;
  endtask

  task automatic test_read();
    int rb = rd_addr_q.size(), tb0 = tx_q.size();
    logic [7:0] exp[4] = '{8'h00, 8'h00, 8'h00, 8'h5A};
    rdata_val = 32'h0000005A;
    drive_frame(8'h52, 32'h40000010, 32'h0, 0);
    checks++;
    if (rd !== 1'b1 || wr !== 1'b0 || addr !== 32'h40000010) begin
      failures++;
      $display("FAIL read_strobe: rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=40000010", rd, wr, addr);
    end
    wait_idle(50, 1'b0);
    checks++;
    if (rd_addr_q.size() - rb != 1 || tx_q.size() - tb0 != 4) begin
      failures++;
      $display("FAIL read_counts: rd=%0d tx=%0d, required 1 4", rd_addr_q.size() - rb, tx_q.size() - tb0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (tx_q[tb0+k] !== exp[k]) begin
          failures++;
          $display("FAIL read_byte%0d: got %h, required %h", k, tx_q[tb0+k], exp[k]);
        end
      end
    end
    model_addr = 32'h40000010;
  endtask

  task automatic test_tx_stall();
    int rb = rd_addr_q.size(), tb0 = tx_q.size(), bad = 0, n = 0;
    logic [31:0] a = $urandom;
    rdata_val = {8'h00, 24'($urandom)};
    tx_ready = 1'b0;
    drive_frame(8'h52, a, 32'h0, 3);
    while (!tx_valid && n < 10) begin tick(); n++; end
    for (int i = 0; i < 20; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'h00) bad++;
      rx_valid = (i == 5);
      rx_data  = 8'h52;
      tick();
    end
    rx_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_hold: %0d of 20 stalled cycles lost tx_valid=1/tx_data=00", bad);
    end
    wait_idle(50, 1'b0);
    checks++;
    if (rd_addr_q.size() - rb != 1 || tx_q.size() - tb0 != 4) begin
      failures++;
      $display("FAIL stall_counts: rd=%0d tx=%0d, required 1 4", rd_addr_q.size() - rb, tx_q.size() - tb0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (tx_q[tb0+k] !== rdata_val[31-8*k -: 8]) begin
          failures++;
          $display("FAIL stall_byte%0d: got %h, required %h", k, tx_q[tb0+k], rdata_val[31-8*k -: 8]);
        end
      end
    end
    model_addr = a;
  endtask

  task automatic test_bad_cmd();
    int wb = wr_addr_q.size(), rb = rd_addr_q.size(), tb0 = tx_q.size();
    logic [31:0] a = $urandom, d = $urandom;
    drive_frame(8'h41, 32'h0, 32'h0, 0);
    wait_idle(50, 1'b0);
    checks++;
    if (wr_addr_q.size() != wb || rd_addr_q.size() != rb || tx_q.size() - tb0 != 1 ||
        tx_q[tx_q.size()-1] !== ERR) begin
      failures++;
      $display("FAIL bad_cmd: wr=%0d rd=%0d tx=%0d last=%h, required 0 0 1 %h",
               wr_addr_q.size() - wb, rd_addr_q.size() - rb, tx_q.size() - tb0, tx_q[tx_q.size()-1], ERR);
    end
    tb0 = tx_q.size();
    drive_frame(8'h57, a, d, 4);
    wait_idle(50, 1'b0);
    checks++;
    if (wr_addr_q.size() - wb != 1 || wr_addr_q[wb] !== a || wr_data_q[wb] !== d ||
        tx_q.size() - tb0 != 1 || tx_q[tb0] !== ACK) begin
      failures++;
      $display("FAIL after_bad_cmd: wr=%0d tx=%0d, required one write to %h=%h and ack",
               wr_addr_q.size() - wb, tx_q.size() - tb0, a, d);
    end
    model_addr = a;
  endtask

  task automatic test_timeout();
    int wb = wr_addr_q.size(), rb = rd_addr_q.size(), tb0 = tx_q.size();
    logic [31:0] partial = {model_addr[15:0], 16'h4000};
    logic [31:0] a = $urandom;
    send_byte(8'h57, 0);
    send_byte(8'h40, 0);
    send_byte(8'h00, 0);
    repeat (TO - 1) tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: busy=%b one cycle before limit, required 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || wr_addr_q.size() != wb || tx_q.size() != tb0 || addr !== partial) begin
      failures++;
      $display("FAIL timeout_abort: busy=%b wr=%0d tx=%0d addr=%h, required 0 0 0 %h",
               busy, wr_addr_q.size() - wb, tx_q.size() - tb0, addr, partial);
    end
    rdata_val = $urandom;
    drive_frame(8'h52, a, 32'h0, 5);
    wait_idle(50, 1'b1);
    checks++;
    if (rd_addr_q.size() - rb != 1 || rd_addr_q[rb] !== a || tx_q.size() - tb0 != 4 ||
        {tx_q[tb0], tx_q[tb0+1], tx_q[tb0+2], tx_q[tb0+3]} !== rdata_val) begin
      failures++;
      $display("FAIL after_timeout: rd=%0d tx=%0d, required one read of %h returning %h",
               rd_addr_q.size() - rb, tx_q.size() - tb0, a, rdata_val);
    end
    model_addr = a;
  endtask

  task automatic test_reset_mid();
    int wb = wr_addr_q.size(), tb0 = tx_q.size();
    logic [31:0] a = $urandom, d = $urandom;
    send_byte(8'h57, 0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({rd, wr, tx_valid, busy, tx_data, addr, wdata} !== '0) begin
      failures++;
      $display("FAIL reset_mid_data: outputs rd=%b wr=%b tv=%b busy=%b td=%h addr=%h wdata=%h, required all 0",
               rd, wr, tx_valid, busy, tx_data, addr, wdata);
    end
    repeat (10) tick();
    checks++;
    if (wr_addr_q.size() != wb || tx_q.size() != tb0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_data_quiet: wr=%0d tx=%0d busy=%b, required 0 0 0",
               wr_addr_q.size() - wb, tx_q.size() - tb0, busy);
    end
    rdata_val = $urandom;
    tx_ready = 1'b0;
    drive_frame(8'h52, $urandom, 32'h0, 0);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({rd, wr, tx_valid, busy, tx_data, addr, wdata} !== '0) begin
      failures++;
      $display("FAIL reset_mid_resp: outputs tv=%b busy=%b td=%h addr=%h, required all 0",
               tx_valid, busy, tx_data, addr);
    end
    tx_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (tx_q.size() != tb0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_resp_quiet: tx=%0d busy=%b, required 0 0", tx_q.size() - tb0, busy);
    end
    wb = wr_addr_q.size();
    drive_frame(8'h57, a, d, 2);
    wait_idle(50, 1'b0);
    checks++;
    if (wr_addr_q.size() - wb != 1 || wr_addr_q[wb] !== a || wr_data_q[wb] !== d ||
        tx_q.size() - tb0 != 1 || tx_q[tb0] !== ACK) begin
      failures++;
      $display("FAIL after_reset: wr=%0d tx=%0d, required one write to %h=%h and ack",
               wr_addr_q.size() - wb, tx_q.size() - tb0, a, d);
    end
    model_addr = a;
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int wb = wr_addr_q.size(), rb = rd_addr_q.size(), tb0 = tx_q.size();
      int sel = $urandom_range(0, 9);
      logic [7:0]  cmd;
      logic [31:0] a = $urandom, d = $urandom;
      logic [7:0]  exp[$];
      int exp_wr, exp_rd;
      if (sel < 4) cmd = 8'h57;
      else if (sel < 8) cmd = 8'h52;
      else begin
        cmd = 8'($urandom);
        while (cmd == 8'h57 || cmd == 8'h52) cmd = 8'($urandom);
      end
      rdata_val = $urandom;
      exp_wr = (cmd == 8'h57) ? 1 : 0;
      exp_rd = (cmd == 8'h52) ? 1 : 0;
      if (cmd == 8'h57) exp.push_back(ACK);
      else if (cmd == 8'h52) for (int k = 0; k < 4; k++) exp.push_back(rdata_val[31-8*k -: 8]);
      else exp.push_back(ERR);
      if (exp_wr + exp_rd != 0) model_addr = a;

      drive_frame(cmd, a, d, 6);
      wait_idle(300, 1'b1);

      checks++;
      if (wr_addr_q.size() - wb != exp_wr || rd_addr_q.size() - rb != exp_rd) begin
        failures++;
        $display("FAIL rand%0d_strobes: cmd=%h wr=%0d rd=%0d, required %0d %0d",
                 it, cmd, wr_addr_q.size() - wb, rd_addr_q.size() - rb, exp_wr, exp_rd);
      end else if (exp_wr == 1) begin
        checks++;
        if (wr_addr_q[wb] !== a || wr_data_q[wb] !== d) begin
          failures++;
          $display("FAIL rand%0d_write: addr=%h data=%h, required %h %h", it, wr_addr_q[wb], wr_data_q[wb], a, d);
        end
      end else if (exp_rd == 1) begin
        checks++;
        if (rd_addr_q[rb] !== a) begin
          failures++;
          $display("FAIL rand%0d_read: addr=%h, required %h", it, rd_addr_q[rb], a);
        end
      end
      checks++;
      if (tx_q.size() - tb0 != exp.size()) begin
        failures++;
        $display("FAIL rand%0d_txcount: got %0d, required %0d", it, tx_q.size() - tb0, exp.size());
      end else begin
        for (int k = 0; k < exp.size(); k++) begin
          checks++;
          if (tx_q[tb0+k] !== exp[k]) begin
            failures++;
            $display("FAIL rand%0d_tx%0d: got %h, required %h", it, k, tx_q[tb0+k], exp[k]);
          end
        end
      end
      checks++;
      if (addr !== model_addr) begin
        failures++;
        $display("FAIL rand%0d_addr_hold: got %h, required %h", it, addr, model_addr);
      end
    end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (overlap != 0) begin
      failures++;
      $display("FAIL rd_wr_overlap: %0d cycles with rd and wr both high, required 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_tx_stall();
    test_bad_cmd();
    test_timeout();
    test_reset_mid();
    test_random();
    test_no_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
